serial_word_feeder: RTL
=======================

# serial_word_feeder

Parallel-to-serial front end for the bit-serial sequence detectors in the FSM library. Accepts WIDTH-bit words over a valid/ready handshake, buffers one pending word, and emits one bit per clock on `x` with framing markers. `x` drives the detector's `x` input directly, and `x_valid` serves as the detector's clock-enable. Back-to-back words stream with no idle gap between them.

## Interface

- `WIDTH`, default 16: word width in bits; legal values 2..64.
- `CW`, default `$clog2(WIDTH)`: width of `bit_idx`. Derived; do not override.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  WIDTH  upstream word.
- `in_ready`  out  1  pending slot empty; a word is accepted in any cycle with `in_valid && in_ready`.
- `hold`  in  1  downstream stall; freezes shifting while high.
- `x`  out  1  current serial bit.
- `x_valid`  out  1  `x` is a live bit this cycle; equals `(state==SHIFT) && !hold`.
- `sof`  out  1  current bit is bit 0 of its word.
- `eof`  out  1  current bit is the last bit of its word.
- `bit_idx`  out  CW  index of current bit within its word, 0..WIDTH-1.
- `busy`  out  1  `state==SHIFT || pend_full`.

## Operation

- Storage:
  - `pend` (WIDTH) and `pend_full`: one-word holding slot.
  - `sr` (WIDTH): shift register.
  - `cnt` (CW): current bit index.
  - `state`: one of IDLE, SHIFT.
- `in_ready = !pend_full && !reset`. It is registered-derived, with no combinational path from `in_valid`.
- Accept: on a clock edge with `in_valid && in_ready`, `pend <= in_data` and `pend_full <= 1`.
- IDLE:
  - If `pend_full`: `sr <= pend`, `cnt <= 0`, clear `pend_full`, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, `hold=1`: `sr`, `cnt` and `state` are frozen. The pending slot may still accept a word.
- SHIFT, `hold=0`, `cnt < WIDTH-1`: shift `sr` one position toward the output end, `cnt <= cnt+1`.
- SHIFT, `hold=0`, `cnt == WIDTH-1`:
  - If `pend_full`: reload `sr <= pend`, `cnt <= 0`, clear `pend_full`, stay in SHIFT.
  - Otherwise go to IDLE.
- Simultaneous accept and reload on the same edge: the new word lands in `pend` and `pend_full` ends at 1. The accept overrides the clear.
- `x` = output-end bit of `sr`, which is `sr[0]` by default.
- `sof = (cnt==0)`, `eof = (cnt==WIDTH-1)`, `bit_idx = cnt`. These three are qualified by `x_valid`; outside `x_valid` their values are don't-care but stable.
- `in_valid` while `in_ready=0`: no effect. Upstream must hold the word until it is accepted.

## Timing

- Reset values:
  - `state=IDLE`, `pend_full=0`, `sr=0`, `cnt=0`.
  - Outputs `x=0`, `x_valid=0`, `sof=1`, `eof=0`, `bit_idx=0`, `busy=0`.
  - `in_ready=0` while `reset` is high, and 1 in the first cycle after release.
- Reset asserted mid-word: at that edge all state clears, and both the pending word and the partial word are discarded.
- Latency from IDLE: handshake in cycle c, bit 0 on `x` with `x_valid=1` in cycle c+2.
- Throughput: one bit per non-held cycle. A word accepted before the current word's `eof` cycle follows with zero gap.
- `in_ready` returns high the cycle after a reload frees the slot. Sustained streaming therefore needs one accept per WIDTH non-held cycles.
- `hold` is combinational into `x_valid` only. Shifting resumes on the first edge with `hold=0`.

## Configuration

- `SER_MSB_FIRST_EN`:
  - Defined: words are emitted MSB first. `x = sr[WIDTH-1]`, and `sr` shifts left.
  - Undefined (default): words are emitted LSB first. `x = sr[0]`, and `sr` shifts right.
- Framing, handshake and latency are identical in both builds.

## Test plan

- Single word, WIDTH=16, LSB first, `in_data=16'b0110110110101100`, `hold=0`:
  - `x` over 16 `x_valid` cycles = 0,0,1,1,0,1,0,1,1,0,1,1,0,1,1,0.
  - `sof` on the first cycle and `eof` on the 16th; `x_valid=0` afterwards.
  - First bit appears at c+2.
- Back-to-back words `16'hA5A5` then `16'h0F0F`, second word offered immediately after the first accept:
  - 32 consecutive `x_valid=1` cycles with no gap.
  - `in_ready=0` while the second word is pending.
  - `sof` at bit 0 and bit 16.
- `hold=1` for 3 cycles at `bit_idx=5`:
  - `x_valid=0` for those 3 cycles, with `x` and `bit_idx` frozen at 5.
  - The stream resumes at bit 5 with no bit lost or duplicated.
- Third word offered while `pend_full=1`: not accepted and `in_ready=0`. It is accepted in the cycle after the reload.
- `reset` pulsed at `bit_idx=9` with a word pending:
  - Next cycle: `x_valid=0`, `busy=0`, `pend_full=0`.
  - After release, `in_ready=1` and no stale bits are emitted.
- `SER_MSB_FIRST_EN` defined, WIDTH=4, `in_data=4'b1000`: `x` = 1,0,0,0, with `eof` on the 4th bit.

Source files
------------

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end: buffers one WIDTH-bit word and streams it one bit per clock with sof/eof framing.
// Build option: define SER_MSB_FIRST_EN to emit MSB first (default emits LSB first).
module serial_word_feeder #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             hold,
    output logic             x,
    output logic             x_valid,
    output logic             sof,
    output logic             eof,
    output logic [CW-1:0]    bit_idx,
    output logic             busy
);

    // Handshake: a word transfers on any rising edge where in_valid && in_ready;
    // in_ready depends only on registered state (and reset), never on in_valid.

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] pend;
    logic             pend_full, pend_full_n;
    logic [WIDTH-1:0] sr, sr_n, sr_shift;
    logic [CW-1:0]    cnt, cnt_n;
    logic             load;
    logic             accept;

    assign in_ready = !pend_full && !reset;
    assign accept   = in_valid && in_ready;

`ifdef SER_MSB_FIRST_EN
    assign sr_shift = {sr[WIDTH-2:0], 1'b0};
    assign x        = sr[WIDTH-1];
`else
    assign sr_shift = {1'b0, sr[WIDTH-1:1]};
    assign x        = sr[0];
`endif

    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (pend_full) begin
                    sr_n    = pend;
                    cnt_n   = '0;
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (!hold) begin
                    if (cnt != LAST) begin
                        sr_n  = sr_shift;
                        cnt_n = cnt + 1'b1;
                    end else if (pend_full) begin
                        // Reload straight from the slot so back-to-back words have no gap.
                        sr_n  = pend;
                        cnt_n = '0;
                        load  = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // An accept on the same edge as a reload wins, leaving the slot full.
        pend_full_n = accept ? 1'b1 : (load ? 1'b0 : pend_full);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pend      <= '0;
            pend_full <= 1'b0;
            sr        <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            pend_full <= pend_full_n;
            sr        <= sr_n;
            cnt       <= cnt_n;
            if (accept) begin
                pend <= in_data;
            end
        end
    end

    assign x_valid = (state == SHIFT) && !hold;
    assign sof     = (cnt == '0);
    assign eof     = (cnt == LAST);
    assign bit_idx = cnt;
    assign busy    = (state == SHIFT) || pend_full;

endmodule
